booth_controller: RTL and testbench

- Sequencing FSM for the team's radix-2 Booth multiplier datapath (6-bit X/Y registers, A accumulator, X-1 flip-flop, add/sub ALU).
- Accepts a start request and drives the datapath's load, init, add/sub and shift strobes for WIDTH iterations, then signals completion.
- Sits between the top-level multiplier wrapper (start/done handshake) and the datapath (control strobes in, X1/X0 status bits back).

---
 rtl/booth_controller.sv | 133 +++++++++++++
 tb/tb_booth_controller.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/booth_controller.sv
// rtl/booth_controller.sv - radix-2 Booth multiplier sequencing FSM; BOOTH_ACK_EN adds a done/ack handshake
module booth_controller #(
    parameter int WIDTH = 6,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
`ifdef BOOTH_ACK_EN
    input  logic ack,
`endif
    input  logic X1,
    input  logic X0,
    output logic ld_X,
    output logic ld_Y,
    output logic ld_A,
    output logic ld_ff,
    output logic init_A,
    output logic init_ff,
    output logic add,
    output logic sub,
    output logic shift_x,
    output logic shift_a,
    output logic busy,
    output logic done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_EVAL  = 3'd2,
        S_SHIFT = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic   [CNT_W-1:0] cnt;
    logic               last_iter;

    // The final SHIFT is the one that completes iteration WIDTH-1.
    assign last_iter = (cnt == CNT_W'(WIDTH - 1));

    // State register; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Iteration counter: cleared on LOAD, advanced once per SHIFT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (state == S_LOAD) begin
            cnt <= '0;
        end else if (state == S_SHIFT) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Next-state and strobe decode; strobes depend on state, plus X1/X0 in EVAL.
    always_comb begin
        state_nxt = state;
        ld_X      = 1'b0;
        ld_Y      = 1'b0;
        ld_A      = 1'b0;
        ld_ff     = 1'b0;
        init_A    = 1'b0;
        init_ff   = 1'b0;
        add       = 1'b0;
        sub       = 1'b0;
        shift_x   = 1'b0;
        shift_a   = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                ld_X      = 1'b1;
                ld_Y      = 1'b1;
                init_A    = 1'b1;
                init_ff   = 1'b1;
                busy      = 1'b1;
                state_nxt = S_EVAL;
            end
            S_EVAL: begin
                busy = 1'b1;
                case ({X1, X0})
                    2'b10: begin
                        sub  = 1'b1;
                        ld_A = 1'b1;
                    end
                    2'b01: begin
                        add  = 1'b1;
                        ld_A = 1'b1;
                    end
                    default: begin
                    end
                endcase
                state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                shift_a   = 1'b1;
                shift_x   = 1'b1;
                ld_ff     = 1'b1;
                busy      = 1'b1;
                state_nxt = last_iter ? S_DONE : S_EVAL;
            end
            S_DONE: begin
                done = 1'b1;
                busy = 1'b1;
`ifdef BOOTH_ACK_EN
                if (ack) begin
                    state_nxt = S_IDLE;
                end
`else
                state_nxt = S_IDLE;
`endif
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_booth_controller.sv
// tb/tb_booth_controller.sv - self-checking bench for booth_controller with a behavioural datapath
module tb_booth_controller;
    localparam int W = 6;

    localparam logic [11:0] V_LD_X    = 12'h800;
    localparam logic [11:0] V_LD_Y    = 12'h400;
    localparam logic [11:0] V_LD_A    = 12'h200;
    localparam logic [11:0] V_LD_FF   = 12'h100;
    localparam logic [11:0] V_INIT_A  = 12'h080;
    localparam logic [11:0] V_INIT_FF = 12'h040;
    localparam logic [11:0] V_ADD     = 12'h020;
    localparam logic [11:0] V_SUB     = 12'h010;
    localparam logic [11:0] V_SHX     = 12'h008;
    localparam logic [11:0] V_SHA     = 12'h004;
    localparam logic [11:0] V_BUSY    = 12'h002;
    localparam logic [11:0] V_DONE    = 12'h001;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic X1, X0;
    logic ld_X, ld_Y, ld_A, ld_ff, init_A, init_ff;
    logic add, sub, shift_x, shift_a, busy, done;
`ifdef BOOTH_ACK_EN
    logic ack;
`endif

    int checks = 0;
    int errors = 0;

    logic [W-1:0] opx = '0;
    logic [W-1:0] opy = '0;
    logic [W-1:0] dx  = '0;
    logic [W-1:0] dy  = '0;
    logic [W:0]   da  = '0;
    logic         dff = 1'b0;
    logic [11:0]  obs_vec;
    logic [11:0]  w_out;

    always #5 clk = ~clk;

    booth_controller #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
`ifdef BOOTH_ACK_EN
        .ack    (ack),
`endif
        .X1     (X1),
        .X0     (X0),
        .ld_X   (ld_X),
        .ld_Y   (ld_Y),
        .ld_A   (ld_A),
        .ld_ff  (ld_ff),
        .init_A (init_A),
        .init_ff(init_ff),
        .add    (add),
        .sub    (sub),
        .shift_x(shift_x),
        .shift_a(shift_a),
        .busy   (busy),
        .done   (done)
    );

    assign X1      = dx[0];
    assign X0      = dff;
    assign w_out   = {da[W-1:0], dx};
    assign obs_vec = {ld_X, ld_Y, ld_A, ld_ff, init_A, init_ff, add, sub, shift_x, shift_a, busy, done};

    always @(posedge clk) begin
        if (ld_X)    dx  <= opx;
        if (ld_Y)    dy  <= opy;
        if (init_A)  da  <= '0;
        if (init_ff) dff <= 1'b0;
        if (ld_A)    da  <= add ? da + {dy[W-1], dy} : da - {dy[W-1], dy};
        if (shift_x) dx  <= {da[0], dx[W-1:1]};
        if (shift_a) da  <= {da[W], da[W:1]};
        if (ld_ff)   dff <= dx[0];
    end

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] exp_vec(input int c, input logic [W-1:0] a);
        logic [11:0] v;
        logic [1:0]  pair;
        int          i;
        v = '0;
        if (c == 1) begin
            v = V_LD_X | V_LD_Y | V_INIT_A | V_INIT_FF | V_BUSY;
        end else if (c >= 2 && c <= 2 * W + 1) begin
            if (c % 2 == 0) begin
                i = (c - 2) / 2;
                pair[1] = a[i];
                pair[0] = 1'b0;
                if (i > 0) pair[0] = a[i-1];
                v = V_BUSY;
                if (pair == 2'b10) v = v | V_SUB | V_LD_A;
                if (pair == 2'b01) v = v | V_ADD | V_LD_A;
            end else begin
                v = V_LD_FF | V_SHX | V_SHA | V_BUSY;
            end
        end else if (c == 2 * W + 2) begin
            v = V_DONE | V_BUSY;
        end
        return v;
    endfunction

    task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b, input int mode);
        int          pa;
        logic [11:0] ep;
        pa = $signed(a) * $signed(b);
        ep = 12'(pa);
        opx = a;
        opy = b;
        start = 1'b1;
        for (int c = 1; c <= 2 * W + 2; c++) begin
            @(posedge clk);
            #1;
            start = (mode == 2) || (mode == 1 && c == 5);
            if (mode == 3 && c == 7) begin
                rst_n = 1'b0;
                #1;
                check("abort_outputs", obs_vec, 12'h000);
                @(posedge clk);
                #1;
                check("abort_hold", obs_vec, 12'h000);
                rst_n = 1'b1;
                return;
            end
            check("strobes", obs_vec, exp_vec(c, a));
            if (c == 2 * W + 2) begin
                check("product", w_out, ep);
            end
        end
        @(posedge clk);
        #1;
        check("idle_after_done", obs_vec, 12'h000);
        if (mode == 2) begin
            @(posedge clk);
            #1;
            check("back_to_back_load", obs_vec, exp_vec(1, a));
            start = 1'b0;
            rst_n = 1'b0;
            @(posedge clk);
            #1;
            rst_n = 1'b1;
        end
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        rst_n = 1'b0;
        start = 1'b1;
`ifdef BOOTH_ACK_EN
        ack = 1'b1;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", obs_vec, 12'h000);
        rst_n = 1'b1;

        run_mul(6'd3,  6'd5,  0);
        run_mul(6'h20, 6'h20, 0);
        run_mul(6'h3F, 6'h1F, 0);
        run_mul(6'd0,  6'h39, 0);
        run_mul(6'd3,  6'd5,  1);
        run_mul(6'd5,  6'd9,  3);
        run_mul(6'd7,  6'h3D, 0);
        run_mul(6'd2,  6'd3,  2);

        for (int n = 0; n < 10; n++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            run_mul(ra, rb, 0);
        end

`ifdef BOOTH_ACK_EN
        ack = 1'b0;
        opx = 6'd3;
        opy = 6'd5;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2 * W + 1) @(posedge clk);
        #1;
        check("ack_done_rise", {10'd0, busy, done}, 12'h003);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check("ack_done_hold", {10'd0, busy, done}, 12'h003);
        end
        ack = 1'b1;
        @(posedge clk);
        #1;
        check("ack_release", obs_vec, 12'h000);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
